uart_status_tx: RTL and testbench
=================================

Name: uart_status_tx

Overview:
UART transmitter for the SDR control link; the return path toward the host USB-UART bridge. It sends single raw bytes (for example, command echo) on request. On a report request it formats the current NCO phase increment and CIC gain as an ASCII status line. It runs in the clk_80mhz domain next to the UART receiver and uses the same bit timing.

Parameters:
- CLKS_PER_BIT, 87, clocks per UART bit; must be ≥ 2.
- PHASE_WIDTH, 64, phase increment width; must be a multiple of 4.
- GAIN_WIDTH, 8, CIC gain width; must be a multiple of 4.

Ports:
- clk, input, 1, system clock (clk_80mhz).
- arst, input, 1, asynchronous active-high reset.
- phase_increment, input, PHASE_WIDTH, current NCO increment; snapshotted at report start.
- cic_gain, input, GAIN_WIDTH, current CIC gain; snapshotted at report start.
- report_req, input, 1, single-cycle pulse requesting one status line.
- byte_valid, input, 1, raw byte offered.
- byte_in, input, 8, raw byte data.
- byte_ready, output, 1, raw byte accepted when byte_valid && byte_ready.
- tx_serial, output, 1, UART line, idle high.
- busy, output, 1, a byte or report is in progress.
- report_done, output, 1, one-cycle pulse after the last stop bit of a report.

Behaviour:
- Reset values (async, while arst = 1): tx_serial = 1, busy = 0, byte_ready = 0, report_done = 0. The FSM goes to IDLE and the pending flag is cleared.
- A reset mid-frame aborts the transfer immediately. The line returns high with no partial stop bit.
- Framing is 8N1, LSB first. Each bit, including start and stop, lasts exactly CLKS_PER_BIT cycles. A 10-bit frame takes 10*CLKS_PER_BIT cycles.
- FSM states: IDLE -> LOAD -> START -> DATA (8 bits) -> STOP.
  - STOP -> LOAD if report characters remain.
  - Otherwise STOP -> IDLE.
- Report line format, all ASCII uppercase hex, MSB nibble first, 23 chars total:
  - 'F'
  - PHASE_WIDTH/4 hex digits of phase_increment
  - ' '
  - 'G'
  - GAIN_WIDTH/4 hex digits of cic_gain
  - CR (0x0D), LF (0x0A)
- Both phase_increment and cic_gain are captured in the cycle the report is accepted. Later input changes do not affect the line in flight.
- report_req while busy:
  - Sets a one-deep pending flag.
  - Further pulses while pending merge into it.
  - The pending report starts when the FSM returns to IDLE.
- byte_ready = 1 only in IDLE with no report pending or being requested. It is registered and drops the cycle after acceptance.
- Simultaneous report_req and byte_valid in IDLE: the report wins and the byte stays un-accepted. byte_valid must be held until accepted.
- Latency: the start bit begins (tx_serial = 0) on the 2nd clock after acceptance (IDLE -> LOAD -> START). Consecutive report characters have one LOAD cycle of idle-high between the stop bit and the next start bit.
- busy is 1 from the cycle after acceptance until the cycle the FSM re-enters IDLE.
- report_done pulses in that same IDLE-entry cycle, and only for reports, not raw bytes.
- The hex nibble-to-ASCII conversion (0-9 -> 0x30-0x39, A-F -> 0x41-0x46) and the character index counter are synchronous. The character index wraps to 0 at report end.

Optional Feature:
- Macro: UART_STATUS_CHECKSUM_EN.
- With the macro defined: before CR LF, insert ' ' plus 2 hex digits of the mod-256 sum of all preceding line characters (from 'F' through the last gain digit). The line becomes 26 chars.
- Without it: the line is exactly as above (23 chars) and no checksum logic is built.

Test Plan:
- Reset: hold arst for 5 cycles mid-frame -> tx_serial = 1 and busy = 0 immediately; no further edges until the next request.
- Raw byte: byte_in = 0x61 ('a') with byte_valid -> line shows 0,1,0,0,0,0,1,1,0 then stop 1 (start bit, LSB-first data, stop). Each bit is 87 clocks; byte_ready is low for the whole frame.
- Report: phase_increment = 64'h04CF41F212D77318, cic_gain = 8'h03, pulse report_req -> decoded "F04CF41F212D77318 G03\r\n" (23 bytes), then a single report_done pulse.
- Snapshot/pending: change phase_increment to 0 mid-report and pulse report_req 3 times -> the first line is unchanged, and exactly one further line "F0000000000000000 G03\r\n" follows.
- Contention: report_req and byte_valid (0x6D) in the same IDLE cycle -> the report is sent first, then 0x6D is accepted and sent after report_done.
- UART_STATUS_CHECKSUM_EN defined, same inputs as the report test -> 26-byte line ending in ' ', then the 2-digit mod-256 sum of the first 21 chars, then CR LF.

Source files
------------

// File: rtl/uart_status_tx.sv
// Purpose: 8N1 UART transmitter for raw bytes and an ASCII "F<phase> G<gain>\r\n" status line.
// Latency: start bit begins 2 clocks after acceptance; one idle-high LOAD cycle between report characters.
// Backpressure: byte_ready/byte_valid handshake; report_req while busy is held in a one-deep pending flag.
// Optional: define UART_STATUS_CHECKSUM_EN to append " XX" (mod-256 sum of the line so far) before CR LF.
module uart_status_tx #(
  parameter int CLKS_PER_BIT = 87,  // must be >= 2
  parameter int PHASE_WIDTH  = 64,  // multiple of 4
  parameter int GAIN_WIDTH   = 8    // multiple of 4
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [PHASE_WIDTH-1:0] phase_increment,
  input  logic [GAIN_WIDTH-1:0]  cic_gain,
  input  logic                   report_req,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_in,
  output logic                   byte_ready,
  output logic                   tx_serial,
  output logic                   busy,
  output logic                   report_done
);

  localparam int NPH       = PHASE_WIDTH / 4;
  localparam int NG        = GAIN_WIDTH / 4;
  localparam int LAST_GAIN = NPH + NG + 2;   // index of the last gain digit
`ifdef UART_STATUS_CHECKSUM_EN
  localparam int NCHARS    = NPH + NG + 8;
`else
  localparam int NCHARS    = NPH + NG + 5;
`endif
  localparam int IDX_W     = $clog2(NCHARS);
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHARS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]             state;
  logic                   pending;
  logic                   is_report;
  logic [IDX_W-1:0]       char_idx;
  logic [CNT_W-1:0]       clk_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic [PHASE_WIDTH-1:0] phase_snap;
  logic [GAIN_WIDTH-1:0]  gain_snap;
  logic [7:0]             cur_char;
  logic [3:0]             nib;
  int                     ci;
  logic                   start_report;
  logic                   accept_byte;
`ifdef UART_STATUS_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // A report (new or pending) always beats a raw byte offered in the same IDLE cycle.
  assign start_report = (state == S_IDLE) && (report_req || pending);
  assign accept_byte  = (state == S_IDLE) && byte_valid && byte_ready && !report_req && !pending;
  assign busy         = (state != S_IDLE);

  // Character generator: selects the ASCII byte for char_idx from the snapshot; registered into shift in LOAD.
  always_comb begin
    ci       = int'(char_idx);
    nib      = 4'h0;
    cur_char = 8'h0A;
    if (ci == 0) begin
      cur_char = 8'h46;                       // 'F'
    end else if (ci <= NPH) begin
      for (int k = 0; k < NPH; k++)
        if (ci == NPH - k) nib = phase_snap[4*k +: 4];
      cur_char = hex_ascii(nib);
    end else if (ci == NPH + 1) begin
      cur_char = 8'h20;                       // ' '
    end else if (ci == NPH + 2) begin
      cur_char = 8'h47;                       // 'G'
    end else if (ci <= LAST_GAIN) begin
      for (int k = 0; k < NG; k++)
        if (ci == LAST_GAIN - k) nib = gain_snap[4*k +: 4];
      cur_char = hex_ascii(nib);
`ifdef UART_STATUS_CHECKSUM_EN
    end else if (ci == LAST_GAIN + 1) begin
      cur_char = 8'h20;
    end else if (ci == LAST_GAIN + 2) begin
      cur_char = hex_ascii(csum[7:4]);
    end else if (ci == LAST_GAIN + 3) begin
      cur_char = hex_ascii(csum[3:0]);
`endif
    end else if (ci == NCHARS - 2) begin
      cur_char = 8'h0D;
    end else begin
      cur_char = 8'h0A;
    end
  end

  // One-deep pending report: set by requests while busy, consumed when IDLE starts the report.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      pending <= 1'b0;
    else if (report_req && state != S_IDLE)
      pending <= 1'b1;
    else if (start_report)
      pending <= 1'b0;
  end

`ifdef UART_STATUS_CHECKSUM_EN
  // Running mod-256 sum of 'F' through the last gain digit, accumulated as each char is loaded.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      csum <= 8'h00;
    else if (start_report)
      csum <= 8'h00;
    else if (state == S_LOAD && is_report && ci <= LAST_GAIN)
      csum <= csum + cur_char;
  end
`endif

  // Main framing FSM: IDLE -> LOAD -> START -> DATA x8 -> STOP, looping through LOAD per report char.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= S_IDLE;
      tx_serial   <= 1'b1;
      byte_ready  <= 1'b0;
      report_done <= 1'b0;
      is_report   <= 1'b0;
      char_idx    <= '0;
      clk_cnt     <= '0;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      phase_snap  <= '0;
      gain_snap   <= '0;
    end else begin
      report_done <= 1'b0;
      byte_ready  <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_serial <= 1'b1;
          if (start_report) begin
            phase_snap <= phase_increment;
            gain_snap  <= cic_gain;
            is_report  <= 1'b1;
            char_idx   <= '0;
            state      <= S_LOAD;
          end else if (accept_byte) begin
            shift     <= byte_in;
            is_report <= 1'b0;
            state     <= S_LOAD;
          end else begin
            byte_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (is_report) shift <= cur_char;
          clk_cnt   <= '0;
          tx_serial <= 1'b0;
          state     <= S_START;
        end
        S_START: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt   <= '0;
            bit_cnt   <= 3'd0;
            tx_serial <= shift[0];
            state     <= S_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx_serial <= 1'b1;
              state     <= S_STOP;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              tx_serial <= shift[1];
              shift     <= shift >> 1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
            if (is_report && char_idx != LAST_IDX) begin
              char_idx <= char_idx + 1'b1;
              state    <= S_LOAD;
            end else begin
              char_idx    <= '0;
              report_done <= is_report;
              state       <= S_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          tx_serial <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_status_tx.sv
// Scoreboard bench for uart_status_tx: stimulus pushes expected bytes, a UART
// line monitor decodes frames and pops/compares; a second monitor counts report_done.
module tb_uart_status_tx;
  localparam int CPB = 87;

  logic        clk = 1'b0;
  logic        arst;
  logic [63:0] phase_increment;
  logic [7:0]  cic_gain;
  logic        report_req;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready;
  logic        tx_serial;
  logic        busy;
  logic        report_done;

  int n_pass  = 0;
  int n_total = 0;
  int done_cnt = 0;
  bit mon_en = 1'b0;
  logic [7:0] exp_q[$];

  uart_status_tx #(.CLKS_PER_BIT(CPB), .PHASE_WIDTH(64), .GAIN_WIDTH(8)) dut (
    .clk(clk), .arst(arst), .phase_increment(phase_increment), .cic_gain(cic_gain),
    .report_req(report_req), .byte_valid(byte_valid), .byte_in(byte_in),
    .byte_ready(byte_ready), .tx_serial(tx_serial), .busy(busy), .report_done(report_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic wait_ready(input string name, input int budget);
    int t = 0;
    while (byte_ready !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (byte_ready !== 1'b1) begin
      n_total++;
      $display("FAIL %s: byte_ready still low after %0d cycles, expected 1", name, t);
    end
  endtask

  // Line monitor: decode one 8N1 frame per start bit, sampling mid-bit.
  initial begin
    logic [7:0] d;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && tx_serial === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        check("start_bit", tx_serial, 1'b0);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clk);
          d[b] = tx_serial;
        end
        repeat (CPB) @(negedge clk);
        check("stop_bit", tx_serial, 1'b1);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_char: got %02h, expected no frame", d);
        end else begin
          e = exp_q.pop_front();
          check("char", d, e);
        end
      end
    end
  end

  // report_done monitor: count pulses; the FSM must already be back in IDLE.
  initial begin
    forever begin
      @(negedge clk);
      if (report_done === 1'b1) begin
        done_cnt++;
        check("done_not_busy", busy, 1'b0);
      end
    end
  end

  initial begin
    int n;
    int bad;
    string l_p3, l_z3, l_pa5;
`ifdef UART_STATUS_CHECKSUM_EN
    l_p3  = "F04CF41F212D77318 G03 8B\r\n";
    l_z3  = "F0000000000000000 G03 10\r\n";
    l_pa5 = "F04CF41F212D77318 GA5 9E\r\n";
`else
    l_p3  = "F04CF41F212D77318 G03\r\n";
    l_z3  = "F0000000000000000 G03\r\n";
    l_pa5 = "F04CF41F212D77318 GA5\r\n";
`endif
    arst = 1'b1; phase_increment = 64'h0; cic_gain = 8'h0;
    report_req = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", tx_serial, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", byte_ready, 1'b0);
    check("rst_done", report_done, 1'b0);
    arst = 1'b0;
    @(negedge clk);

    // Reset mid-frame aborts immediately (monitor off)
    wait_ready("rst_idle", 10);
    byte_in = 8'h00; byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (300) @(negedge clk);
    check("pre_reset_low", tx_serial, 1'b0);
    arst = 1'b1;
    #1;
    check("abort_tx", tx_serial, 1'b1);
    check("abort_busy", busy, 1'b0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("reset_hold", bad, 0);
    arst = 1'b0;
    bad = 0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("quiet_after_reset", bad, 0);
    mon_en = 1'b1;

    // Raw byte 0x61 with latency, bit-length and frame-length checks
    wait_ready("raw_ready", 10);
    byte_in = 8'h61; byte_valid = 1'b1;
    exp_q.push_back(8'h61);
    @(negedge clk);
    byte_valid = 1'b0;
    check("load_idle_high", tx_serial, 1'b1);
    check("busy_after_accept", busy, 1'b1);
    check("ready_dropped", byte_ready, 1'b0);
    @(negedge clk);
    check("start_latency", tx_serial, 1'b0);
    n = 0;
    while (tx_serial === 1'b0 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("start_len", n, CPB);
    bad = 0;
    while (busy === 1'b1 && n < 5000) begin
      if (byte_ready !== 1'b0) bad++;
      n++;
      @(negedge clk);
    end
    check("frame_len", n, 10 * CPB);
    check("ready_low_frame", bad, 0);

    // Report, then snapshot + merged pending requests
    wait_ready("rep_ready", 100);
    phase_increment = 64'h04CF41F212D77318; cic_gain = 8'h03;
    report_req = 1'b1;
    push_line(l_p3);
    @(negedge clk);
    report_req = 1'b0;
    check("busy_after_req", busy, 1'b1);
    repeat (3 * (10 * CPB + 1)) @(negedge clk);
    phase_increment = 64'h0;
    push_line(l_z3);
    repeat (3) begin
      report_req = 1'b1;
      @(negedge clk);
      report_req = 1'b0;
      repeat (5) @(negedge clk);
    end
    n = 0;
    while (done_cnt < 2 && n < 60000) begin
      n++;
      @(negedge clk);
    end
    check("two_reports_done", done_cnt, 2);

    // Contention: report and raw byte together; report first, byte after report_done
    wait_ready("cont_ready", 100);
    phase_increment = 64'h04CF41F212D77318; cic_gain = 8'hA5;
    report_req = 1'b1; byte_valid = 1'b1; byte_in = 8'h6D;
    push_line(l_pa5);
    exp_q.push_back(8'h6D);
    @(negedge clk);
    report_req = 1'b0;
    check("cont_busy", busy, 1'b1);
    wait_ready("cont_byte_ready", 30000);
    check("byte_after_done", done_cnt, 3);
    @(negedge clk);
    byte_valid = 1'b0;

    // Drain
    n = 0;
    while ((exp_q.size() != 0 || busy === 1'b1) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("done_total", done_cnt, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #(10 * 99000);
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
